// File: rtl/pipe_stage_pkg.sv
// Shared types for the pipeline-stage register: occupancy encoding and helpers.
package pipe_stage_pkg;

    // Encoded so that the state value is the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Request bits carried beside every payload (dREN, dWEN).
    localparam int unsigned REQ_BITS = 2;

    function automatic logic [1:0] occ_count(input occ_t s);
        return logic'(s[1]) ? 2'd2 : (logic'(s[0]) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry: payload plus pending dREN/dWEN request bits.
// Control priority: clear (to BUBBLE) > load > request clear.
module pipe_entry_reg
    import pipe_stage_pkg::*;
#(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             req_clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dren_i,
    input  logic             dwen_i,
    output logic [WIDTH-1:0] data_o,
    output logic             dren_o,
    output logic             dwen_o
);

    // Width-dependent entry layout {payload, dREN, dWEN}.
    typedef struct packed {
        logic [WIDTH-1:0]    payload;
        logic [REQ_BITS-1:0] req;
    } pipe_entry_t;

    pipe_entry_t entry_q, entry_d;

    // Next entry value from clear/load/retire controls.
    always_comb begin
        entry_d = entry_q;
        if (clear_i) begin
            entry_d.payload = BUBBLE;
            entry_d.req     = '0;
        end else if (load_i) begin
            entry_d.payload = data_i;
            entry_d.req     = {dren_i, dwen_i};
        end else if (req_clr_i) begin
            entry_d.req     = '0;
        end
    end

    // Entry storage, reset to an empty bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entry_q.payload <= BUBBLE;
            entry_q.req     <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign data_o = entry_q.payload;
    assign dren_o = entry_q.req[1];
    assign dwen_o = entry_q.req[0];

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, flush-to-bubble and head data-memory request tracking.
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int unsigned       WIDTH  = 32,
    parameter int unsigned       SKID   = 1,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dREN,
    input  logic             in_dWEN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_dREN,
    output logic             out_dWEN,
    input  logic             dhit,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    occ_t occ_q, occ_d;

    logic             push, pop;
    logic             head_load, head_from_skid, skid_load;
    logic [WIDTH-1:0] head_data_in, head_data, skid_data;
    logic             head_dren_in, head_dwen_in;
    logic             head_dren, head_dwen, skid_dren, skid_dwen;

    assign out_valid = (occ_q != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy transitions and head/skid load steering; flush overrides all.
    always_comb begin
        occ_d          = occ_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push && (SKID != 0)) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_TWO;
                    end else if (pop) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        occ_d          = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) occ_q <= OCC_EMPTY;
        else       occ_q <= occ_d;
    end

    // Head refills from skid when draining TWO, otherwise from the input.
    always_comb begin
        head_data_in = in_data;
        head_dren_in = in_dREN;
        head_dwen_in = in_dWEN;
        if (head_from_skid) begin
            head_data_in = skid_data;
            head_dren_in = skid_dren;
            head_dwen_in = skid_dwen;
        end
    end

    // A pop refill takes priority over dhit inside the entry register, so the
    // new head keeps its own request bits.
    pipe_entry_reg #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_head (
        .CLK       (CLK),
        .nRST      (nRST),
        .load_i    (head_load),
        .clear_i   (flush),
        .req_clr_i (dhit & out_valid),
        .data_i    (head_data_in),
        .dren_i    (head_dren_in),
        .dwen_i    (head_dwen_in),
        .data_o    (head_data),
        .dren_o    (head_dren),
        .dwen_o    (head_dwen)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_entry_reg #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
                .CLK       (CLK),
                .nRST      (nRST),
                .load_i    (skid_load),
                .clear_i   (flush),
                .req_clr_i (1'b0),
                .data_i    (in_data),
                .dren_i    (in_dREN),
                .dwen_i    (in_dWEN),
                .data_o    (skid_data),
                .dren_o    (skid_dren),
                .dwen_o    (skid_dwen)
            );

            // Registered ready taken from next state so it drops with TWO.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) in_ready_q <= 1'b1;
                else       in_ready_q <= (occ_d != OCC_TWO);
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_data = '0;
            assign skid_dren = 1'b0;
            assign skid_dwen = 1'b0;
            assign in_ready  = ~out_valid | out_ready;
        end
    endgenerate

    assign out_data  = head_data;
    assign out_dREN  = head_dren & out_valid;
    assign out_dWEN  = head_dwen & out_valid;
    assign occupancy = occ_count(occ_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1 instance (a_*, BUBBLE=DEADBEEF) and SKID=0 instance (b_*).
module tb_pipe_stage_skid;

    logic        CLK = 1'b0;
    logic        nRST;
    int          checks = 0;
    int          failures = 0;

    logic        a_in_valid, a_in_ready, a_in_dREN, a_in_dWEN;
    logic [31:0] a_in_data, a_out_data;
    logic        a_out_valid, a_out_ready, a_out_dREN, a_out_dWEN, a_dhit, a_flush;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_in_dREN, b_in_dWEN;
    logic [31:0] b_in_data, b_out_data;
    logic        b_out_valid, b_out_ready, b_out_dREN, b_out_dWEN, b_dhit, b_flush;
    logic [1:0]  b_occ;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.WIDTH(32), .SKID(1), .BUBBLE(32'hDEAD_BEEF)) dut_a (
        .CLK(CLK), .nRST(nRST),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_dREN(a_in_dREN), .in_dWEN(a_in_dWEN),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_dREN(a_out_dREN), .out_dWEN(a_out_dWEN),
        .dhit(a_dhit), .flush(a_flush), .occupancy(a_occ)
    );

    pipe_stage_skid #(.WIDTH(32), .SKID(0), .BUBBLE(32'h0)) dut_b (
        .CLK(CLK), .nRST(nRST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_dREN(b_in_dREN), .in_dWEN(b_in_dWEN),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_dREN(b_out_dREN), .out_dWEN(b_out_dWEN),
        .dhit(b_dhit), .flush(b_flush), .occupancy(b_occ)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
        checks++; if (a_out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL reset_data got=%h exp=deadbeef", a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++; if ({a_out_dREN, a_out_dWEN} !== 2'b00) begin failures++; $display("FAIL reset_req got=%b exp=00", {a_out_dREN, a_out_dWEN}); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_data = 32'(i);
            tick();
            checks++; if (a_out_data !== 32'(i) || a_out_valid !== 1'b1) begin failures++; $display("FAIL stream_data%0d got=%h/%b exp=%h/1", i, a_out_data, a_out_valid, i); end
            checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_occ%0d got=%0d/%b exp=1/1", i, a_occ, a_in_ready); end
        end
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0d/%b exp=0/0", a_occ, a_out_valid); end
        checks++; if (a_out_data !== 32'h3) begin failures++; $display("FAIL stream_lastpop got=%h exp=3", a_out_data); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_skid();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        tick();
        checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_one got=%0d/%b exp=1/1", a_occ, a_in_ready); end
        a_in_data = 32'hB;
        tick();
        checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin failures++; $display("FAIL skid_full got=%0d/%b exp=2/0", a_occ, a_in_ready); end
        checks++; if (a_out_data !== 32'hA) begin failures++; $display("FAIL skid_head got=%h exp=a", a_out_data); end
        a_in_data   = 32'hC;
        tick();
        checks++; if (a_occ !== 2'd2 || a_out_data !== 32'hA) begin failures++; $display("FAIL skid_hold got=%0d/%h exp=2/a", a_occ, a_out_data); end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_out_data !== 32'hB || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_drain1 got=%h/%0d/%b exp=b/1/1", a_out_data, a_occ, a_in_ready); end
        tick();
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL skid_drain2 got=%0d/%b exp=0/0", a_occ, a_out_valid); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_mem_retire();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h55;
        a_in_dREN   = 1'b1;
        tick();
        checks++; if ({a_out_dREN, a_out_dWEN} !== 2'b10) begin failures++; $display("FAIL mem_pending got=%b exp=10", {a_out_dREN, a_out_dWEN}); end
        a_in_valid = 1'b0;
        a_in_dREN  = 1'b0;
        a_dhit     = 1'b1;
        #1;
        checks++; if (a_out_dREN !== 1'b1) begin failures++; $display("FAIL mem_no_comb got=%b exp=1", a_out_dREN); end
        tick();
        a_dhit = 1'b0;
        checks++; if (a_out_dREN !== 1'b0 || a_out_data !== 32'h55 || a_out_valid !== 1'b1) begin failures++; $display("FAIL mem_retired got=%b/%h/%b exp=0/55/1", a_out_dREN, a_out_data, a_out_valid); end
        // queue a write-request entry behind the head, then pop with dhit
        a_in_valid = 1'b1;
        a_in_data  = 32'h66;
        a_in_dWEN  = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        a_in_dWEN   = 1'b0;
        a_dhit      = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_dhit      = 1'b0;
        a_out_ready = 1'b0;
        checks++; if (a_out_data !== 32'h66 || {a_out_dREN, a_out_dWEN} !== 2'b01) begin failures++; $display("FAIL mem_pop_dhit got=%h/%b exp=66/01", a_out_data, {a_out_dREN, a_out_dWEN}); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h11;
        a_in_dREN   = 1'b1;
        tick();
        a_in_data = 32'h22;
        a_in_dREN = 1'b0;
        a_in_dWEN = 1'b1;
        tick();
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL flush_setup got=%0d exp=2", a_occ); end
        a_flush     = 1'b1;
        a_in_data   = 32'h33;
        a_in_dREN   = 1'b1;
        a_out_ready = 1'b1;
        a_dhit      = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_dhit = 1'b0; a_out_ready = 1'b0;
        a_in_dREN = 1'b0; a_in_dWEN = 1'b0;
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", a_occ, a_out_valid); end
        checks++; if (a_out_data !== 32'hDEADBEEF || {a_out_dREN, a_out_dWEN} !== 2'b00) begin failures++; $display("FAIL flush_bubble got=%h/%b exp=deadbeef/00", a_out_data, {a_out_dREN, a_out_dWEN}); end
        // flush at occupancy 1 with an acceptable push: the push is dropped
        a_in_valid = 1'b1;
        a_in_data  = 32'h44;
        tick();
        a_in_data = 32'h45;
        a_flush   = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        checks++; if (a_occ !== 2'd0 || a_out_data !== 32'hDEADBEEF || a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_drop got=%0d/%h/%b exp=0/deadbeef/1", a_occ, a_out_data, a_in_ready); end
        tick();
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_stays got=%0d/%b exp=0/0", a_occ, a_out_valid); end
    endtask

    task automatic test_noskid();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h7;
        tick();
        b_in_valid = 1'b0;
        #1;
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h7) begin failures++; $display("FAIL b_load got=%b/%h exp=1/7", b_out_valid, b_out_data); end
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL b_stall got=%b exp=0", b_in_ready); end
        b_in_valid = 1'b1;
        b_in_data  = 32'h9;
        tick();
        checks++; if (b_out_data !== 32'h7 || b_occ !== 2'd1) begin failures++; $display("FAIL b_hold got=%h/%0d exp=7/1", b_out_data, b_occ); end
        b_out_ready = 1'b1;
        b_in_data   = 32'h8;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL b_comb_ready got=%b exp=1", b_in_ready); end
        tick();
        checks++; if (b_out_data !== 32'h8 || b_occ !== 2'd1 || b_out_valid !== 1'b1) begin failures++; $display("FAIL b_replace got=%h/%0d/%b exp=8/1/1", b_out_data, b_occ, b_out_valid); end
        b_in_valid = 1'b0;
        tick();
        checks++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL b_drain got=%0d/%b exp=0/0", b_occ, b_out_valid); end
        b_out_ready = 1'b0;
    endtask

    initial begin
        nRST = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_dREN = 1'b0; a_in_dWEN = 1'b0;
        a_out_ready = 1'b0; a_dhit = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_dREN = 1'b0; b_in_dWEN = 1'b0;
        b_out_ready = 1'b0; b_dhit = 1'b0; b_flush = 1'b0;
        #12;
        test_reset();
        test_streaming();
        test_skid();
        test_mem_retire();
        test_flush();
        test_noskid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
